// File: rtl/bet_entry_if.sv
// Keyboard/bet-bus bundle between the PS/2 front end, the bet entry FSM and the wheel controller.
interface bet_entry_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [2:0] color;
    logic       round_done;
    logic [7:0] bet_data;
    logic       bet_valid;
    logic [3:0] bet_index;
    logic       spin;
    logic [5:0] entry_num;
    logic [3:0] bet_count;
    logic       err;

    modport master (
        output rx_byte, rx_valid, color, round_done,
        input  bet_data, bet_valid, bet_index, spin, entry_num, bet_count, err
    );

    modport slave (
        input  rx_byte, rx_valid, color, round_done,
        output bet_data, bet_valid, bet_index, spin, entry_num, bet_count, err
    );
endinterface

// File: rtl/bet_entry_fsm.sv
// Roulette bet entry: decodes PS/2 set-2 keys into numbered, coloured bets and spin requests.
// Optional macro BET_TIMEOUT_EN discards a partial entry after TIMEOUT_CYCLES idle cycles.
module bet_entry_fsm #(
    parameter int unsigned MAX_BETS       = 12,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic        clock,
    input logic        reset,
    bet_entry_if.slave bus
);
    localparam int unsigned NUM_W      = 6;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SUM_W      = 7;
    localparam int unsigned MAX_NUMBER = 36;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {IDLE, DIG1, DIG2, SPINNING} state_t;
    typedef enum logic [2:0] {KEY_NONE, KEY_DIGIT, KEY_ENTER, KEY_BKSP, KEY_SPACE} key_t;

    if (MAX_BETS < 1 || MAX_BETS > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("bet_entry_fsm: MAX_BETS must be 1..15 and TIMEOUT_CYCLES at least 1");
    end

    state_t             state, state_nx;
    logic [NUM_W-1:0]   value, value_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic               brk, brk_nx, ext, ext_nx;
    logic [7:0]         data_nx;
    logic [CNT_W-1:0]   index_nx;
    logic               valid_nx, spin_nx, err_nx;
    key_t               key;
    logic [3:0]         digit;
    logic [SUM_W-1:0]   sum;
    logic               act;
    logic               timeout_c;

    // Scan-code decode of the current byte
    always_comb begin : decode
        key   = KEY_NONE;
        digit = 4'd0;
        case (bus.rx_byte)
            8'h45: begin key = KEY_DIGIT; digit = 4'd0; end
            8'h16: begin key = KEY_DIGIT; digit = 4'd1; end
            8'h1E: begin key = KEY_DIGIT; digit = 4'd2; end
            8'h26: begin key = KEY_DIGIT; digit = 4'd3; end
            8'h25: begin key = KEY_DIGIT; digit = 4'd4; end
            8'h2E: begin key = KEY_DIGIT; digit = 4'd5; end
            8'h36: begin key = KEY_DIGIT; digit = 4'd6; end
            8'h3D: begin key = KEY_DIGIT; digit = 4'd7; end
            8'h3E: begin key = KEY_DIGIT; digit = 4'd8; end
            8'h46: begin key = KEY_DIGIT; digit = 4'd9; end
            8'h5A: key = KEY_ENTER;
            8'h66: key = KEY_BKSP;
            8'h29: key = KEY_SPACE;
            default: ;
        endcase
    end

    assign sum = SUM_W'(value) * SUM_W'(10) + SUM_W'(digit);

`ifdef BET_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] idle_cnt;
    logic             in_entry;

    assign in_entry  = (state == DIG1) || (state == DIG2);
    assign timeout_c = in_entry && !bus.rx_valid && (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, only live while a number is half entered
    always_ff @(posedge clock) begin : idle_timer
        if (reset || !in_entry || bus.rx_valid || bus.round_done) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TMR_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next state, datapath and strobes; round_done outranks any key byte
    always_comb begin : next_state
        state_nx = state;
        value_nx = value;
        count_nx = count;
        brk_nx   = brk;
        ext_nx   = ext;
        data_nx  = bus.bet_data;
        index_nx = bus.bet_index;
        valid_nx = 1'b0;
        spin_nx  = 1'b0;
        err_nx   = 1'b0;
        act      = 1'b0;

        if (bus.round_done) begin
            state_nx = IDLE;
            value_nx = '0;
            count_nx = '0;
            brk_nx   = 1'b0;
            ext_nx   = 1'b0;
        end else if (bus.rx_valid) begin
            if (bus.rx_byte == BREAK_CODE) begin
                brk_nx = 1'b1;
            end else if (bus.rx_byte == EXT_CODE) begin
                ext_nx = 1'b1;
            end else begin
                brk_nx = 1'b0;
                ext_nx = 1'b0;
                act    = !brk && (!ext || key == KEY_ENTER) && (state != SPINNING);
            end
        end else if (timeout_c) begin
            state_nx = IDLE;
            value_nx = '0;
        end

        if (act) begin
            case (key)
                KEY_DIGIT: begin
                    if (state == IDLE) begin
                        value_nx = NUM_W'(digit);
                        state_nx = DIG1;
                    end else if (state == DIG1 && sum <= SUM_W'(MAX_NUMBER)) begin
                        value_nx = NUM_W'(sum);
                        state_nx = DIG2;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                KEY_ENTER: begin
                    if (state == DIG1 || state == DIG2) begin
                        if (bus.color != 3'b000 && count < CNT_W'(MAX_BETS)) begin
                            valid_nx = 1'b1;
                            data_nx  = {bus.color[1:0], value};
                            index_nx = count;
                            count_nx = count + CNT_W'(1);
                            value_nx = '0;
                            state_nx = IDLE;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end
                KEY_BKSP: begin
                    if (state == DIG2) begin
                        value_nx = value / NUM_W'(10);
                        state_nx = DIG1;
                    end else if (state == DIG1) begin
                        value_nx = '0;
                        state_nx = IDLE;
                    end
                end
                KEY_SPACE: begin
                    if (state == IDLE && count != '0) begin
                        spin_nx  = 1'b1;
                        state_nx = SPINNING;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin : regs
        if (reset) begin
            state         <= IDLE;
            value         <= '0;
            count         <= '0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            bus.bet_data  <= '0;
            bus.bet_index <= '0;
            bus.bet_valid <= 1'b0;
            bus.spin      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_nx;
            value         <= value_nx;
            count         <= count_nx;
            brk           <= brk_nx;
            ext           <= ext_nx;
            bus.bet_data  <= data_nx;
            bus.bet_index <= index_nx;
            bus.bet_valid <= valid_nx;
            bus.spin      <= spin_nx;
            bus.err       <= err_nx;
        end
    end

    // value is zero whenever no number is being entered
    assign bus.entry_num = value;
    assign bus.bet_count = count;
endmodule

// File: tb/tb_bet_entry_fsm.sv
// Self-checking bench for bet_entry_fsm: directed scenarios plus random key traffic vs. a digit-list model.
module tb_bet_entry_fsm;
    localparam int unsigned MAX_BETS = 12;
    localparam int unsigned TMO      = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bet_entry_if bus ();

    bet_entry_fsm #(.MAX_BETS(MAX_BETS), .TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: the entry is a list of typed digits
    int          digits[$];
    bit          spinning, brk_m, ext_m;
    int          cnt_m, idx_m, idle_m;
    logic [7:0]  data_m;
    bit          valid_m, spin_m, err_m;
    logic [2:0]  col_cur = 3'b010;
    logic [7:0]  dig_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int entry_value();
        int v = 0;
        foreach (digits[i]) v = v * 10 + digits[i];
        return v;
    endfunction

    function automatic int digit_of(input logic [7:0] b);
        for (int i = 0; i < 10; i++) if (dig_codes[i] == b) return i;
        return -1;
    endfunction

    task automatic apply_key(input logic [7:0] b, input logic [2:0] col);
        int d;
        int v;
        d = digit_of(b);
        if (d >= 0) begin
            if (digits.size() == 0) digits.push_back(d);
            else if (digits.size() == 1 && digits[0] * 10 + d <= 36) digits.push_back(d);
            else err_m = 1;
        end else if (b == 8'h5A) begin
            if (digits.size() > 0) begin
                if (col != 3'b000 && cnt_m < MAX_BETS) begin
                    v       = entry_value();
                    valid_m = 1;
                    data_m  = {col[1:0], v[5:0]};
                    idx_m   = cnt_m;
                    cnt_m++;
                    digits.delete();
                end else err_m = 1;
            end
        end else if (b == 8'h66) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end else if (b == 8'h29) begin
            if (digits.size() == 0 && cnt_m > 0) begin
                spin_m   = 1;
                spinning = 1;
            end else err_m = 1;
        end
    endtask

    task automatic model_step(input bit rst, input bit rd, input bit v, input logic [7:0] b,
                              input logic [2:0] col);
        valid_m = 0; spin_m = 0; err_m = 0;
        if (rst) begin
            digits.delete(); spinning = 0; brk_m = 0; ext_m = 0;
            cnt_m = 0; idx_m = 0; data_m = 8'h00; idle_m = 0;
        end else if (rd) begin
            digits.delete(); spinning = 0; brk_m = 0; ext_m = 0; cnt_m = 0; idle_m = 0;
        end else if (v) begin
            idle_m = 0;
            if (b == 8'hF0) brk_m = 1;
            else if (b == 8'hE0) ext_m = 1;
            else begin
                bit act;
                act   = !brk_m && (!ext_m || b == 8'h5A) && !spinning;
                brk_m = 0;
                ext_m = 0;
                if (act) apply_key(b, col);
            end
        end else if (digits.size() > 0) begin
            idle_m++;
`ifdef BET_TIMEOUT_EN
            if (idle_m >= TMO) begin
                digits.delete();
                idle_m = 0;
            end
`endif
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output
    task automatic step(input bit rst, input bit rd, input bit v, input logic [7:0] b);
        @(negedge clock);
        reset          = rst;
        bus.round_done = rd;
        bus.rx_valid   = v;
        bus.rx_byte    = b;
        bus.color      = col_cur;
        @(posedge clock);
        #1;
        model_step(rst, rd, v, b, col_cur);
        check("bet_valid", 32'(bus.bet_valid), 32'(valid_m));
        check("spin",      32'(bus.spin),      32'(spin_m));
        check("err",       32'(bus.err),       32'(err_m));
        check("bet_data",  32'(bus.bet_data),  32'(data_m));
        check("bet_index", 32'(bus.bet_index), 32'(idx_m));
        check("bet_count", 32'(bus.bet_count), 32'(cnt_m));
        check("entry_num", 32'(bus.entry_num), 32'(entry_value()));
    endtask

    task automatic key(input logic [7:0] b);
        step(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic round_done();
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    logic [7:0] rnd_codes[15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h5A, 8'h66, 8'h29, 8'hF0, 8'hE0};

    initial begin
        bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.color = 3'b000; bus.round_done = 1'b0;

        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_data",  32'(bus.bet_data),  32'h0);
        check("rst_count", 32'(bus.bet_count), 32'h0);

        // Number 21 with break codes interleaved, colour 2
        col_cur = 3'b010;
        key(8'h1E); key(8'hF0); key(8'h1E); key(8'h16); key(8'hF0); key(8'h16); key(8'h5A);
        check("r39_valid", 32'(bus.bet_valid), 32'h1);
        check("r39_data",  32'(bus.bet_data),  32'h95);
        check("r39_index", 32'(bus.bet_index), 32'h0);
        check("r39_count", 32'(bus.bet_count), 32'h1);

        // 3 then 7 gives 37 > 36
        key(8'h26);
        check("r40_entry3", 32'(bus.entry_num), 32'd3);
        key(8'h3D);
        check("r40_err",    32'(bus.err),       32'h1);
        check("r40_keep",   32'(bus.entry_num), 32'd3);
        key(8'h66);
        check("r40_bksp",   32'(bus.entry_num), 32'd0);
        round_done();

        // Fill every slot, then one more
        for (int i = 0; i < int'(MAX_BETS); i++) begin
            col_cur = 3'(1 + (i % 7));
            key(dig_codes[i % 10]);
            key(8'h5A);
            check("fill_idx", 32'(bus.bet_index), 32'(i));
        end
        key(8'h2E); key(8'h5A);
        check("r41_err",   32'(bus.err),       32'h1);
        check("r41_valid", 32'(bus.bet_valid), 32'h0);
        check("r41_count", 32'(bus.bet_count), 32'd12);
        check("r41_entry", 32'(bus.entry_num), 32'd5);
        round_done();

        // Colour none rejects Enter
        col_cur = 3'b000;
        key(8'h16); key(8'h5A);
        check("nocol_err", 32'(bus.err), 32'h1);
        key(8'h66);
        col_cur = 3'b101;

        // Spin flow
        key(8'h29);
        check("r42_err0",  32'(bus.err), 32'h1);
        key(8'h45); key(8'h5A); key(8'h29);
        check("r42_spin",  32'(bus.spin), 32'h1);
        key(8'h25); key(8'h5A); key(8'h29);
        check("r42_ign",   32'(bus.entry_num), 32'd0);
        round_done();
        check("r42_clear", 32'(bus.bet_count), 32'd0);

        // Reset mid-DIG2 after three bets
        for (int i = 0; i < 3; i++) begin key(dig_codes[i + 1]); key(8'h5A); end
        key(8'h1E); key(8'h46);
        check("r43_pre", 32'(bus.entry_num), 32'd29);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("r43_count", 32'(bus.bet_count), 32'd0);
        check("r43_entry", 32'(bus.entry_num), 32'd0);

        // Idle timeout boundary
        key(8'h25);
        for (int i = 0; i < int'(TMO) - 1; i++) idle_cycle();
        check("tmo_pre", 32'(bus.entry_num), 32'd4);
        idle_cycle();
`ifdef BET_TIMEOUT_EN
        check("tmo_entry", 32'(bus.entry_num), 32'd0);
`else
        check("tmo_entry", 32'(bus.entry_num), 32'd4);
`endif
        key(8'hE0); key(8'h5A);
        round_done();

        // Random key traffic
        for (int n = 0; n < 4000; n++) begin
            bit         rst, rd, v;
            logic [7:0] b;
            int         r;
            rst = ($urandom_range(0, 499) == 0);
            rd  = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 1) == 1);
            r   = $urandom_range(0, 17);
            b   = (r < 15) ? rnd_codes[r] : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) col_cur = 3'($urandom_range(0, 7));
            step(rst, rd, v, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
